// File: rtl/axi_w_burst_drain.sv
// Drains len+1 beats per burst command from a first-word-fall-through FIFO
// onto a W channel through a single registered output slot.
module axi_w_burst_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pull,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_wlast,
    output logic                  burst_done,
    output logic                  busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LEN_WIDTH-1:0]    r_len_q;
    logic [LEN_WIDTH:0]      r_issue_cnt;
    logic                    r_all_issued;
    logic                    r_wvalid;
    logic                    r_wlast;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_burst_done;

    logic                    w_load;
    logic                    w_accept;
    logic                    w_hs;
    logic                    w_hs_last;
    logic                    w_is_last;

    assign w_hs      = r_wvalid && m_wready;
    assign w_hs_last = w_hs && r_wlast;
    assign w_accept  = cmd_valid && cmd_ready;
    // Counter is one bit wider than len so a full 2^LEN_WIDTH-beat burst never wraps.
    assign w_is_last = (r_issue_cnt == {1'b0, r_len_q});

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = !srst;
                if (cmd_valid && !srst) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_load = !srst && !fifo_empty && !r_all_issued && (!r_wvalid || m_wready);
                if (w_hs_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst bookkeeping: length, issued-beat count, completion pulse.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_len_q      <= '0;
            r_issue_cnt  <= '0;
            r_all_issued <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= w_hs_last;
            if (w_accept) begin
                r_len_q      <= cmd_len;
                r_issue_cnt  <= '0;
                r_all_issued <= 1'b0;
            end else if (w_load) begin
                r_issue_cnt <= r_issue_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
                if (w_is_last) begin
                    r_all_issued <= 1'b1;
                end
            end
        end
    end

    // Output slot: a load replaces the slot even when it drains in the same cycle.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_wdata  <= '0;
        end else if (w_load) begin
            r_wvalid <= 1'b1;
            r_wlast  <= w_is_last;
            r_wdata  <= fifo_data;
        end else if (w_hs) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
        end
    end

    assign fifo_pull  = w_load;
    assign m_wvalid   = r_wvalid;
    assign m_wdata    = r_wdata;
    assign m_wlast    = r_wlast;
    assign burst_done = r_burst_done;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_axi_w_burst_drain.sv
// Bench for axi_w_burst_drain: FIFO and W-sink models, event log, per-scenario checks.
module tb_axi_w_burst_drain;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          aclk = 1'b0;
    logic          srst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          m_wready = 1'b0;
    logic          cmd_ready, fifo_pull, m_wvalid, m_wlast, burst_done, busy;
    logic [DW-1:0] m_wdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] feedq[$];
    logic [DW-1:0] exp_d[$];
    int  feed_per = 0;
    int  feed_cnt = 0;
    bit  pop_pending = 1'b0;
    int  rmode = 0;
    int  rcnt = 0;

    int            acc_cyc[$];
    int            pull_cyc[$];
    int            hs_cyc[$];
    int            done_cyc[$];
    logic [DW-1:0] hs_d[$];
    bit            hs_l[$];
    int  n_pull_empty, n_pull_stall, n_unstable, n_rst_viol;
    bit  prev_stall, prev_srst, prev_l;
    logic [DW-1:0] prev_d;

    axi_w_burst_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .aclk(aclk), .srst(srst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pull(fifo_pull), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wlast(m_wlast), .burst_done(burst_done), .busy(busy)
    );

    always #5 aclk = ~aclk;

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    // FIFO and W-sink models update just after each rising edge.
    initial forever begin
        @(posedge aclk);
        #1;
        if (pop_pending && fq.size() > 0) void'(fq.pop_front());
        pop_pending = 1'b0;
        if (feed_per > 0) begin
            feed_cnt++;
            if (feed_cnt >= feed_per && feedq.size() > 0) begin
                fq.push_back(feedq.pop_front());
                feed_cnt = 0;
            end
        end
        refresh();
        case (rmode)
            0: m_wready = 1'b1;
            1: begin m_wready = (rcnt % 3 == 0); rcnt++; end
            default: m_wready = 1'($urandom_range(0, 1));
        endcase
    end

    // Event log sampled on the falling edge.
    initial forever begin
        @(negedge aclk);
        if (srst && (cmd_ready || fifo_pull)) n_rst_viol++;
        if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
        if (fifo_pull) begin
            pull_cyc.push_back(cyc);
            if (fifo_empty) n_pull_empty++;
            if (m_wvalid && !m_wready) n_pull_stall++;
        end
        pop_pending = fifo_pull;
        if (prev_stall && !prev_srst && (m_wvalid !== 1'b1 || m_wdata !== prev_d || m_wlast !== prev_l))
            n_unstable++;
        if (m_wvalid && m_wready) begin
            hs_cyc.push_back(cyc);
            hs_d.push_back(m_wdata);
            hs_l.push_back(m_wlast);
        end
        if (burst_done) done_cyc.push_back(cyc);
        prev_stall = m_wvalid && !m_wready;
        prev_srst  = srst;
        prev_d     = m_wdata;
        prev_l     = m_wlast;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int at_i(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [DW-1:0] at_d(input logic [DW-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 'x;
    endfunction

    function automatic logic at_l(input bit q[$], input int i);
        return (i < q.size()) ? q[i] : 1'bx;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic clr();
        acc_cyc.delete(); pull_cyc.delete(); hs_cyc.delete(); done_cyc.delete();
        hs_d.delete(); hs_l.delete();
        n_pull_empty = 0; n_pull_stall = 0; n_unstable = 0; n_rst_viol = 0;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) fq.push_back(DW'($urandom));
        refresh();
    endtask

    task automatic snap(input int n);
        exp_d.delete();
        for (int i = 0; i < n; i++) exp_d.push_back(fq[i]);
    endtask

    task automatic send_cmd(input int len);
        cmd_len = LW'(len);
        cmd_valid = 1'b1;
        for (int k = 0; k < 20 && acc_cyc.size() == 0; k++) tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int k = 0; k < budget && done_cyc.size() < n; k++) tick(1);
        tick(1);
    endtask

    task automatic test_reset();
        clr();
        srst = 1'b1; cmd_valid = 1'b1; cmd_len = 8'd5;
        fq.delete(); preload(1);
        tick(3);
        checks++; if (m_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got=%b exp=0", m_wvalid); end
        checks++; if (m_wlast !== 1'b0) begin errors++; $display("FAIL rst_wlast got=%b exp=0", m_wlast); end
        checks++; if (m_wdata !== '0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", m_wdata); end
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", burst_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
        checks++; if (fifo_pull !== 1'b0) begin errors++; $display("FAIL rst_pull got=%b exp=0", fifo_pull); end
        srst = 1'b0; cmd_valid = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_cmd_ready got=%b exp=1", cmd_ready); end
        tick(1);
        checks++; if (acc_cyc.size() != 0 || n_rst_viol != 0) begin errors++; $display("FAIL rst_accept got=%0d/%0d exp=0/0", acc_cyc.size(), n_rst_viol); end
        fq.delete(); refresh();
    endtask

    task automatic test_single();
        int t;
        logic [DW-1:0] r;
        clr(); rmode = 0;
        fq.delete(); fq.push_back(16'hA5A5); r = DW'($urandom); fq.push_back(r); refresh();
        send_cmd(0);
        wait_done(1, 20);
        t = at_i(acc_cyc, 0);
        checks++; if (hs_d.size() != 1) begin errors++; $display("FAIL single_hs_count got=%0d exp=1", hs_d.size()); end
        checks++; if (at_d(hs_d, 0) !== 16'hA5A5) begin errors++; $display("FAIL single_data got=%h exp=a5a5", at_d(hs_d, 0)); end
        checks++; if (at_l(hs_l, 0) !== 1'b1) begin errors++; $display("FAIL single_last got=%b exp=1", at_l(hs_l, 0)); end
        checks++; if (at_i(pull_cyc, 0) != t + 1 || pull_cyc.size() != 1) begin errors++; $display("FAIL single_pull got=%0d n=%0d exp=%0d n=1", at_i(pull_cyc, 0), pull_cyc.size(), t + 1); end
        checks++; if (at_i(hs_cyc, 0) != t + 2) begin errors++; $display("FAIL single_hs_cycle got=%0d exp=%0d", at_i(hs_cyc, 0), t + 2); end
        checks++; if (at_i(done_cyc, 0) != t + 3 || done_cyc.size() != 1) begin errors++; $display("FAIL single_done got=%0d exp=%0d", at_i(done_cyc, 0), t + 3); end
        checks++; if (fq.size() != 1 || at_d(fq, 0) !== r) begin errors++; $display("FAIL single_residual got=%0d/%h exp=1/%h", fq.size(), at_d(fq, 0), r); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stream();
        int t;
        logic [DW-1:0] r1, r2;
        clr(); rmode = 0;
        fq.delete();
        for (int i = 1; i <= 4; i++) fq.push_back(DW'(i));
        r1 = DW'($urandom); r2 = DW'($urandom);
        fq.push_back(r1); fq.push_back(r2); refresh();
        send_cmd(3);
        wait_done(1, 30);
        t = at_i(acc_cyc, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (at_d(hs_d, i) !== DW'(i + 1)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, at_d(hs_d, i), i + 1); end
            checks++; if (at_l(hs_l, i) !== (i == 3)) begin errors++; $display("FAIL stream_last[%0d] got=%b exp=%b", i, at_l(hs_l, i), i == 3); end
            checks++; if (at_i(hs_cyc, i) != t + 2 + i) begin errors++; $display("FAIL stream_cycle[%0d] got=%0d exp=%0d", i, at_i(hs_cyc, i), t + 2 + i); end
        end
        checks++; if (pull_cyc.size() != 4 || hs_d.size() != 4) begin errors++; $display("FAIL stream_counts pulls=%0d hs=%0d exp=4/4", pull_cyc.size(), hs_d.size()); end
        checks++; if (at_i(done_cyc, 0) != t + 6) begin errors++; $display("FAIL stream_done got=%0d exp=%0d", at_i(done_cyc, 0), t + 6); end
        checks++; if (fq.size() != 2 || at_d(fq, 0) !== r1 || at_d(fq, 1) !== r2) begin errors++; $display("FAIL stream_residual got=%0d exp=2", fq.size()); end
    endtask

    task automatic test_backpressure();
        clr(); rmode = 1; rcnt = 0;
        fq.delete(); preload(5); snap(4);
        send_cmd(3);
        wait_done(1, 100);
        checks++; if (hs_d.size() != 4) begin errors++; $display("FAIL bp_hs_count got=%0d exp=4", hs_d.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (at_d(hs_d, i) !== exp_d[i] || at_l(hs_l, i) !== (i == 3)) begin errors++; $display("FAIL bp_beat[%0d] got=%h/%b exp=%h/%b", i, at_d(hs_d, i), at_l(hs_l, i), exp_d[i], i == 3); end
        end
        checks++; if (n_unstable != 0) begin errors++; $display("FAIL bp_stable got=%0d changes exp=0", n_unstable); end
        checks++; if (n_pull_stall != 0) begin errors++; $display("FAIL bp_pull_stalled got=%0d exp=0", n_pull_stall); end
        checks++; if (pull_cyc.size() != 4 || done_cyc.size() != 1 || fq.size() != 1) begin errors++; $display("FAIL bp_counts pulls=%0d done=%0d left=%0d exp=4/1/1", pull_cyc.size(), done_cyc.size(), fq.size()); end
        rmode = 0;
    endtask

    task automatic test_underflow();
        clr(); rmode = 0;
        fq.delete(); refresh(); feedq.delete(); exp_d.delete();
        for (int i = 0; i < 4; i++) feedq.push_back(DW'($urandom));
        for (int i = 0; i < 3; i++) exp_d.push_back(feedq[i]);
        feed_cnt = 0; feed_per = 3;
        send_cmd(2);
        wait_done(1, 100);
        feed_per = 0;
        checks++; if (n_pull_empty != 0) begin errors++; $display("FAIL uf_pull_empty got=%0d exp=0", n_pull_empty); end
        checks++; if (hs_d.size() != 3) begin errors++; $display("FAIL uf_hs_count got=%0d exp=3", hs_d.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (at_d(hs_d, i) !== exp_d[i] || at_l(hs_l, i) !== (i == 2)) begin errors++; $display("FAIL uf_beat[%0d] got=%h/%b exp=%h/%b", i, at_d(hs_d, i), at_l(hs_l, i), exp_d[i], i == 2); end
        end
        checks++; if (at_i(hs_cyc, 1) - at_i(hs_cyc, 0) <= 1 || at_i(hs_cyc, 2) - at_i(hs_cyc, 1) <= 1) begin errors++; $display("FAIL uf_gaps got=%0d,%0d,%0d exp=spaced", at_i(hs_cyc, 0), at_i(hs_cyc, 1), at_i(hs_cyc, 2)); end
        checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL uf_done got=%0d exp=1", done_cyc.size()); end
        feedq.delete(); fq.delete(); refresh();
    endtask

    task automatic test_max_len();
        int nbad;
        clr(); rmode = 0;
        fq.delete(); preload(257); snap(257);
        cmd_len = 8'd255; cmd_valid = 1'b1;
        for (int k = 0; k < 20 && acc_cyc.size() < 1; k++) tick(1);
        cmd_len = 8'd0;
        for (int k = 0; k < 600 && acc_cyc.size() < 2; k++) tick(1);
        cmd_valid = 1'b0;
        wait_done(2, 20);
        checks++; if (acc_cyc.size() != 2 || hs_d.size() != 257 || pull_cyc.size() != 257) begin errors++; $display("FAIL max_counts acc=%0d hs=%0d pulls=%0d exp=2/257/257", acc_cyc.size(), hs_d.size(), pull_cyc.size()); end
        nbad = 0;
        for (int i = 0; i < 257; i++) begin
            checks++;
            if (at_d(hs_d, i) !== exp_d[i] || at_l(hs_l, i) !== (i >= 255)) begin
                errors++; nbad++;
                if (nbad <= 4) $display("FAIL max_beat[%0d] got=%h/%b exp=%h/%b", i, at_d(hs_d, i), at_l(hs_l, i), exp_d[i], i >= 255);
            end
        end
        checks++; if (at_i(done_cyc, 0) != at_i(acc_cyc, 0) + 258) begin errors++; $display("FAIL max_done got=%0d exp=%0d", at_i(done_cyc, 0), at_i(acc_cyc, 0) + 258); end
        checks++; if (at_i(acc_cyc, 1) != at_i(done_cyc, 0)) begin errors++; $display("FAIL b2b_accept got=%0d exp=%0d", at_i(acc_cyc, 1), at_i(done_cyc, 0)); end
        checks++; if (at_i(done_cyc, 1) != at_i(acc_cyc, 1) + 3) begin errors++; $display("FAIL b2b_done got=%0d exp=%0d", at_i(done_cyc, 1), at_i(acc_cyc, 1) + 3); end
        checks++; if (fq.size() != 0) begin errors++; $display("FAIL max_residual got=%0d exp=0", fq.size()); end
    endtask

    task automatic test_reset_mid();
        clr(); rmode = 0;
        fq.delete(); preload(12);
        send_cmd(7);
        for (int k = 0; k < 40 && hs_d.size() < 2; k++) tick(1);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        #1;
        checks++; if (m_wvalid !== 1'b0 || m_wlast !== 1'b0) begin errors++; $display("FAIL rmid_wvalid got=%b/%b exp=0/0", m_wvalid, m_wlast); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_cmd_ready got=%b exp=1", cmd_ready); end
        tick(5);
        checks++; if (done_cyc.size() != 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", done_cyc.size()); end
        clr(); snap(2);
        send_cmd(1);
        wait_done(1, 20);
        checks++; if (hs_d.size() != 2 || done_cyc.size() != 1) begin errors++; $display("FAIL rmid_fresh hs=%0d done=%0d exp=2/1", hs_d.size(), done_cyc.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (at_d(hs_d, i) !== exp_d[i] || at_l(hs_l, i) !== (i == 1)) begin errors++; $display("FAIL rmid_beat[%0d] got=%h/%b exp=%h/%b", i, at_d(hs_d, i), at_l(hs_l, i), exp_d[i], i == 1); end
        end
    endtask

    task automatic test_random();
        int len, extra;
        for (int it = 0; it < 4; it++) begin
            clr(); rmode = 2;
            fq.delete();
            len = $urandom_range(0, 9);
            extra = $urandom_range(0, 2);
            preload(len + 1 + extra); snap(len + 1);
            send_cmd(len);
            wait_done(1, 200);
            checks++; if (hs_d.size() != len + 1 || pull_cyc.size() != len + 1) begin errors++; $display("FAIL rnd%0d_counts hs=%0d pulls=%0d exp=%0d", it, hs_d.size(), pull_cyc.size(), len + 1); end
            for (int i = 0; i <= len; i++) begin
                checks++; if (at_d(hs_d, i) !== exp_d[i] || at_l(hs_l, i) !== (i == len)) begin errors++; $display("FAIL rnd%0d_beat[%0d] got=%h/%b exp=%h/%b", it, i, at_d(hs_d, i), at_l(hs_l, i), exp_d[i], i == len); end
            end
            checks++; if (n_unstable != 0 || n_pull_stall != 0) begin errors++; $display("FAIL rnd%0d_stable got=%0d/%0d exp=0/0", it, n_unstable, n_pull_stall); end
            checks++; if (fq.size() != extra || done_cyc.size() != 1) begin errors++; $display("FAIL rnd%0d_end left=%0d done=%0d exp=%0d/1", it, fq.size(), done_cyc.size(), extra); end
        end
        rmode = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_underflow();
        test_max_len();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
